// File: rtl/jtag_dmi_bridge.sv
// rtl/jtag_dmi_bridge.sv - JTAG DTM to debug-module register port bridge
// Synchronizes the DTM request level and runs one register access per request pulse.
module jtag_dmi_bridge #(
  parameter int DMI_ADDR_BITS  = 6,
  parameter int DMI_DATA_BITS  = 32,
  parameter int DMI_OP_BITS    = 2,
  parameter int DTM_REQ_BITS   = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     dtm_req_valid,
  input  logic [DTM_REQ_BITS-1:0]  dtm_req_data,
  output logic                     dm_is_busy,
  output logic [DTM_REQ_BITS-1:0]  dm_resp_data,
  output logic                     dmi_req_valid,
  input  logic                     dmi_req_ready,
  output logic                     dmi_we,
  output logic [DMI_ADDR_BITS-1:0] dmi_addr,
  output logic [DMI_DATA_BITS-1:0] dmi_wdata,
  input  logic                     dmi_resp_valid,
  input  logic [DMI_DATA_BITS-1:0] dmi_rdata
);
  localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_BITS-1:0]    CNT_MAX  = CNT_BITS'(TIMEOUT_CYCLES - 1);
  localparam logic [DMI_OP_BITS-1:0] OP_NOP   = DMI_OP_BITS'(0);
  localparam logic [DMI_OP_BITS-1:0] OP_READ  = DMI_OP_BITS'(1);
  localparam logic [DMI_OP_BITS-1:0] OP_WRITE = DMI_OP_BITS'(2);
  localparam logic [DMI_OP_BITS-1:0] OP_FAIL  = DMI_OP_BITS'(2);

  typedef enum logic [2:0] {IDLE, ACCESS, WAIT_RESP, DONE, RELEASE} state_e;

  state_e                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic [DTM_REQ_BITS-1:0]  req_q, req_d;
  logic [DTM_REQ_BITS-1:0]  resp_q, resp_d;
  logic [DMI_DATA_BITS-1:0] rdata_q, rdata_d;
  logic [DMI_OP_BITS-1:0]   rop_q, rop_d;
  logic [CNT_BITS-1:0]      cnt_q, cnt_d;
  logic                     busy_q, busy_d;
  logic                     req_s;

  logic [DMI_ADDR_BITS-1:0] req_addr;
  logic [DMI_OP_BITS-1:0]   req_op;

  assign req_s    = sync_q[SYNC_STAGES-1];
  assign req_addr = req_q[DTM_REQ_BITS-1 -: DMI_ADDR_BITS];
  assign req_op   = req_q[DMI_OP_BITS-1:0];

  assign dm_is_busy    = busy_q;
  assign dm_resp_data  = resp_q;
  assign dmi_req_valid = (state_q == ACCESS);
  assign dmi_we        = (req_op == OP_WRITE);
  assign dmi_addr      = req_addr;
  assign dmi_wdata     = req_q[DMI_OP_BITS +: DMI_DATA_BITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync_q  <= '0;
      req_q   <= '0;
      resp_q  <= '0;
      rdata_q <= '0;
      rop_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], dtm_req_valid};
      req_q   <= req_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      rop_q   <= rop_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    resp_d  = resp_q;
    rdata_d = rdata_q;
    rop_d   = rop_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        // dtm_req_data is only guaranteed stable once the synchronized level is seen
        if (req_s) begin
          req_d   = dtm_req_data;
          busy_d  = 1'b1;
          rdata_d = '0;
          rop_d   = OP_NOP;
          case (dtm_req_data[DMI_OP_BITS-1:0])
            OP_READ, OP_WRITE: state_d = ACCESS;
            OP_NOP:            state_d = DONE;
            default: begin
              rop_d   = OP_FAIL;
              state_d = DONE;
            end
          endcase
        end
      end
      ACCESS: begin
        if (dmi_req_ready) begin
          cnt_d   = '0;
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        // a response in the timeout cycle still counts as success
        if (dmi_resp_valid) begin
          rdata_d = (req_op == OP_WRITE) ? '0 : dmi_rdata;
          rop_d   = OP_NOP;
          state_d = DONE;
        end else if (cnt_q == CNT_MAX) begin
          rdata_d = '0;
          rop_d   = OP_FAIL;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_BITS'(1);
        end
      end
      DONE: begin
        resp_d  = {req_addr, rdata_q, rop_q};
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!req_s) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_jtag_dmi_bridge.sv
// tb/tb_jtag_dmi_bridge.sv - randomized self-checking bench for jtag_dmi_bridge
module tb_jtag_dmi_bridge;
  localparam int TO = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dtm_req_valid = 1'b0;
  logic [39:0] dtm_req_data = '0;
  logic        dm_is_busy;
  logic [39:0] dm_resp_data;
  logic        dmi_req_valid;
  logic        dmi_req_ready = 1'b0;
  logic        dmi_we;
  logic [5:0]  dmi_addr;
  logic [31:0] dmi_wdata;
  logic        dmi_resp_valid = 1'b0;
  logic [31:0] dmi_rdata = '0;

  int n_chk = 0;
  int n_fail = 0;

  jtag_dmi_bridge dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dtm_req_valid  (dtm_req_valid),
    .dtm_req_data   (dtm_req_data),
    .dm_is_busy     (dm_is_busy),
    .dm_resp_data   (dm_resp_data),
    .dmi_req_valid  (dmi_req_valid),
    .dmi_req_ready  (dmi_req_ready),
    .dmi_we         (dmi_we),
    .dmi_addr       (dmi_addr),
    .dmi_wdata      (dmi_wdata),
    .dmi_resp_valid (dmi_resp_valid),
    .dmi_rdata      (dmi_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected DTM response from the access outcome: nop/reserved never touch the port,
  // an access fails only if no response arrives within TO cycles of waiting.
  function automatic logic [39:0] model(input logic [1:0] op, input logic [5:0] addr,
                                        input logic [31:0] rd, input int resp_dly);
    if (op == 2'd0) return {addr, 32'h0, 2'd0};
    if (op == 2'd3) return {addr, 32'h0, 2'd2};
    if (resp_dly >= TO) return {addr, 32'h0, 2'd2};
    return {addr, (op == 2'd1) ? rd : 32'h0, 2'd0};
  endfunction

  task automatic txn(input logic [1:0] op, input logic [5:0] addr, input logic [31:0] data,
                     input int ready_dly, input int resp_dly, input logic [31:0] rd,
                     input int hold);
    int n, acc, vcyc, k, bad;
    bit hs, prev_v;
    logic [39:0] exp;
    exp = model(op, addr, rd, resp_dly);
    acc = 0; vcyc = 0; k = 0; bad = 0; hs = 0; prev_v = 0;
    @(negedge clk);
    dtm_req_data  = {addr, data, op};
    dtm_req_valid = 1'b1;
    n = 0;
    while (!dm_is_busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("busy_rise", 40'(n), 40'd3);
    for (int c = 0; c < hold; c++) begin
      if (dmi_req_ready) begin
        dmi_req_ready = 1'b0;
        hs = 1'b1;
      end
      if (dmi_req_valid && !prev_v) acc++;
      prev_v = dmi_req_valid;
      if (dmi_req_valid) begin
        vcyc++;
        if ({dmi_we, dmi_addr, dmi_wdata} !== {op == 2'd2, addr, data}) bad++;
        if (vcyc == ready_dly + 1) dmi_req_ready = 1'b1;
      end
      if (hs) begin
        dmi_resp_valid = (k == resp_dly);
        dmi_rdata      = (k == resp_dly) ? rd : $urandom;
        k++;
      end
      @(negedge clk);
    end
    dmi_resp_valid = 1'b0;
    dmi_req_ready  = 1'b0;
    dtm_req_valid  = 1'b0;
    n = 0;
    while (dm_is_busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("busy_fall", 40'(n), 40'd3);
    chk("resp_data", dm_resp_data, exp);
    chk("access_cnt", 40'(acc), (op == 2'd1 || op == 2'd2) ? 40'd1 : 40'd0);
    if (op == 2'd1 || op == 2'd2) begin
      chk("req_hold", 40'(vcyc), 40'(ready_dly + 1));
      chk("req_fields", 40'(bad), 40'd0);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [5:0]  r_addr;
    logic [31:0] r_data, r_rd;
    int          r_rdy, r_rsp;

    repeat (3) @(negedge clk);
    chk("rst_busy", 40'(dm_is_busy), 40'd0);
    chk("rst_resp", dm_resp_data, 40'd0);
    chk("rst_req", {dmi_req_valid, dmi_we, dmi_addr, dmi_wdata}, 40'd0);
    rst_n = 1'b1;
    @(negedge clk);

    txn(2'd1, 6'h11, 32'h0, 0, 0, 32'hDEADBEEF, 20);
    txn(2'd2, 6'h05, 32'h12345678, 5, 3, 32'hFFFF0000, 30);
    txn(2'd1, 6'h3F, 32'h0, 1, 300, 32'hA5A5A5A5, 320);
    txn(2'd1, 6'h21, 32'h0, 0, TO - 1, 32'hCAFEF00D, TO + 20);
    txn(2'd1, 6'h22, 32'h0, 0, TO, 32'h0BADF00D, TO + 20);
    txn(2'd0, 6'h07, 32'hFFFFFFFF, 0, 0, 32'h1, 50);
    txn(2'd3, 6'h2A, 32'h55555555, 0, 0, 32'h1, 50);
    txn(2'd2, 6'h30, 32'h87654321, 0, 0, 32'h1, 50);

    for (int i = 0; i < 20; i++) begin
      r_op   = 2'($urandom_range(0, 3));
      r_addr = 6'($urandom);
      r_data = $urandom;
      r_rd   = $urandom;
      r_rdy  = $urandom_range(0, 5);
      r_rsp  = $urandom_range(0, 8);
      txn(r_op, r_addr, r_data, r_rdy, r_rsp, r_rd, r_rdy + r_rsp + 12);
    end

    // Reset while an access is outstanding in WAIT_RESP
    @(negedge clk);
    dtm_req_data  = {6'h2A, 32'h0, 2'd1};
    dtm_req_valid = 1'b1;
    dmi_req_ready = 1'b1;
    repeat (6) @(negedge clk);
    dmi_req_ready = 1'b0;
    chk("mid_busy", 40'(dm_is_busy), 40'd1);
    chk("mid_valid", 40'(dmi_req_valid), 40'd0);
    #2 rst_n = 1'b0;
    dtm_req_valid = 1'b0;
    #1;
    chk("arst_busy", 40'(dm_is_busy), 40'd0);
    chk("arst_resp", dm_resp_data, 40'd0);
    chk("arst_req", {dmi_req_valid, dmi_we, dmi_addr, dmi_wdata}, 40'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_busy", 40'(dm_is_busy), 40'd0);
    chk("post_rst_valid", 40'(dmi_req_valid), 40'd0);
    txn(2'd1, 6'h0C, 32'h0, 2, 1, 32'h13579BDF, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
